// File: rtl/path_player.sv
// path_player: replays a solver move stream across the maze grid,
// checking each step against maze memory for walls, exits and goal.
//
// Ports:
//   clk, rst          clock (rising) / async active-low reset
//   start             restart replay from the start cell
//   move_valid/ready  move handshake; move_in 00=up 01=right 10=left 11=down
//   move_last         final move of the sequence
//   addr, dout        maze memory {row,col} address / wall bit (1=wall)
//   row, col          committed position
//   pos_valid         pulse on a committed legal step
//   step_count        legal steps committed, saturating at 255
//   done_o, fail_o    sticky goal-reached / illegal-path flags
module path_player #(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ROW  = 0,
  parameter int START_COL  = 0,
  parameter int GOAL_ROW   = 2**(ADDR_WIDTH/2)-1,
  parameter int GOAL_COL   = 2**(ADDR_WIDTH/2)-1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    move_valid,
  input  logic [1:0]              move_in,
  input  logic                    move_last,
  output logic                    move_ready,
  output logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    dout,
  output logic [ADDR_WIDTH/2-1:0] row,
  output logic [ADDR_WIDTH/2-1:0] col,
  output logic                    pos_valid,
  output logic [7:0]              step_count,
  output logic                    done_o,
  output logic                    fail_o
);

  localparam int HW = ADDR_WIDTH / 2;

  localparam logic [HW-1:0] L_SR  = HW'(START_ROW);
  localparam logic [HW-1:0] L_SC  = HW'(START_COL);
  localparam logic [HW-1:0] L_GR  = HW'(GOAL_ROW);
  localparam logic [HW-1:0] L_GC  = HW'(GOAL_COL);
  localparam logic [HW-1:0] L_ONE = HW'(1);
  localparam logic [HW-1:0] L_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          r_state;
  logic [HW-1:0]   r_row;
  logic [HW-1:0]   r_col;
  logic [HW-1:0]   r_cand_row;
  logic [HW-1:0]   r_cand_col;
  logic            r_last;
  logic            r_ready;
  logic            r_pos_valid;
  logic [7:0]      r_step;
  logic            r_done;
  logic            r_fail;

  logic [HW-1:0]   w_nrow;
  logic [HW-1:0]   w_ncol;
  logic            w_oob;
  logic            w_goal;
  logic            w_accept;

  // Candidate cell from the current position; edges are rejected
  // rather than wrapped.
  always_comb begin
    w_nrow = r_row;
    w_ncol = r_col;
    w_oob  = 1'b0;
    unique case (move_in)
      2'b00: begin
        w_oob  = (r_row == '0);
        w_nrow = r_row - L_ONE;
      end
      2'b01: begin
        w_oob  = (r_col == L_MAX);
        w_ncol = r_col + L_ONE;
      end
      2'b10: begin
        w_oob  = (r_col == '0);
        w_ncol = r_col - L_ONE;
      end
      2'b11: begin
        w_oob  = (r_row == L_MAX);
        w_nrow = r_row + L_ONE;
      end
      default: ;
    endcase
  end

  assign w_goal   = (r_cand_row == L_GR) && (r_cand_col == L_GC);
  assign w_accept = move_valid && r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_row       <= L_SR;
      r_col       <= L_SC;
      r_cand_row  <= L_SR;
      r_cand_col  <= L_SC;
      r_last      <= 1'b0;
      r_ready     <= 1'b0;
      r_pos_valid <= 1'b0;
      r_step      <= 8'd0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_pos_valid <= 1'b0;
      if (start) begin
        // Restart wins over everything, dropping any in-flight move.
        r_state    <= S_WAIT;
        r_row      <= L_SR;
        r_col      <= L_SC;
        r_cand_row <= L_SR;
        r_cand_col <= L_SC;
        r_last     <= 1'b0;
        r_ready    <= 1'b1;
        r_step     <= 8'd0;
        r_done     <= 1'b0;
        r_fail     <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_WAIT: begin
            if (w_accept) begin
              r_last  <= move_last;
              r_ready <= 1'b0;
              if (w_oob) begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
              end else begin
                r_cand_row <= w_nrow;
                r_cand_col <= w_ncol;
                r_state    <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (dout) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_row       <= r_cand_row;
              r_col       <= r_cand_col;
              r_pos_valid <= 1'b1;
              if (r_step != 8'hFF) begin
                r_step <= r_step + 8'd1;
              end
              // Reaching the goal outranks a latched last flag.
              if (w_goal) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (r_last) begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
              end else begin
                r_state <= S_WAIT;
                r_ready <= 1'b1;
              end
            end
          end
          S_DONE: ;
          S_FAIL: ;
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign move_ready = r_ready;
  assign addr       = {r_cand_row, r_cand_col};
  assign row        = r_row;
  assign col        = r_col;
  assign pos_valid  = r_pos_valid;
  assign step_count = r_step;
  assign done_o     = r_done;
  assign fail_o     = r_fail;

endmodule

// File: tb/tb_path_player.sv
// tb_path_player: randomized and directed replay sequences checked
// against a grid-walk reference model through a commit scoreboard.
module tb_path_player;

  localparam int N = 16;

  typedef struct {
    int r;
    int c;
    int s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_in = 2'b00;
  logic       move_last = 1'b0;
  logic       move_ready;
  logic [7:0] addr;
  logic       dout;
  logic [3:0] row;
  logic [3:0] col;
  logic       pos_valid;
  logic [7:0] step_count;
  logic       done_o;
  logic       fail_o;

  logic       mem [0:255];
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         mv[$];
  bit         ls[$];

  assign dout = mem[addr];

  path_player dut (
    .clk(clk), .rst(rst), .start(start),
    .move_valid(move_valid), .move_in(move_in),
    .move_last(move_last), .move_ready(move_ready),
    .addr(addr), .dout(dout), .row(row), .col(col),
    .pos_valid(pos_valid), .step_count(step_count),
    .done_o(done_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Commit monitor: every pos_valid pulse must match the next
  // expected commit produced by the model.
  always @(negedge clk) begin
    if (rst) begin
      if (done_o && fail_o) chk("done_and_fail", 1, 0);
      if (pos_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pos_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_row", int'(row), e.r);
          chk("commit_col", int'(col), e.c);
          chk("commit_steps", int'(step_count), e.s);
        end
      end
    end
  end

  task automatic clear_mem(input int wall_pct);
    for (int i = 0; i < 256; i++)
      mem[i] = (i != 0) && (($urandom % 100) < wall_pct);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done", done_o, 0);
    chk("start_fail", fail_o, 0);
    chk("start_steps", step_count, 0);
    chk("start_row", row, 0);
    chk("start_col", col, 0);
    chk("start_ready", move_ready, 1);
  endtask

  // Outcome codes: 0 step ok, 1 goal, 2 last w/o goal, 3 wall, 4 exit.
  task automatic run_seq(input int m[$], input bit l[$], input bit hold);
    int r, c, s, nr, nc, o;
    int oc[$];
    r = 0; c = 0; s = 0;
    for (int k = 0; k < m.size(); k++) begin
      nr = r; nc = c;
      case (m[k])
        0: nr = r - 1;
        1: nc = c + 1;
        2: nc = c - 1;
        default: nr = r + 1;
      endcase
      if (nr < 0 || nr >= N || nc < 0 || nc >= N) o = 4;
      else if (mem[nr * N + nc]) o = 3;
      else begin
        r = nr; c = nc; s++;
        exp_q.push_back('{r, c, (s > 255) ? 255 : s});
        if (r == N - 1 && c == N - 1) o = 1;
        else if (l[k]) o = 2;
        else o = 0;
      end
      oc.push_back(o);
      if (o != 0) break;
    end
    for (int k = 0; k < oc.size(); k++) begin
      chk("ready_in_wait", move_ready, 1);
      if (!hold) begin
        repeat ($urandom % 3) begin
          move_valid = 1'b0;
          move_in = 2'($urandom);
          @(negedge clk);
        end
      end
      move_valid = 1'b1;
      move_in = 2'(m[k]);
      move_last = l[k];
      @(negedge clk);
      if (oc[k] == 4) begin
        chk("exit_fail", fail_o, 1);
        chk("exit_done", done_o, 0);
        chk("exit_ready", move_ready, 0);
        break;
      end
      chk("ready_in_check", move_ready, 0);
      move_valid = hold ? 1'b1 : 1'($urandom);
      move_in = 2'($urandom);
      move_last = 1'($urandom);
      @(negedge clk);
      chk("flag_done", done_o, int'(oc[k] == 1));
      chk("flag_fail", fail_o, int'(oc[k] >= 2));
      if (oc[k] != 0) break;
    end
    move_valid = 1'b0;
    @(negedge clk);
    chk("final_row", row, r);
    chk("final_col", col, c);
    chk("final_steps", step_count, (s > 255) ? 255 : s);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic add_mv(input int m, input bit l);
    mv.push_back(m);
    ls.push_back(l);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", move_ready, 0);
    chk("rst_addr", addr, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_pos_valid", pos_valid, 0);
    chk("rst_steps", step_count, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fail", fail_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", move_ready, 0);

    // Full diagonal-free walk to the goal with valid held high.
    clear_mem(0);
    mv.delete(); ls.delete();
    for (int i = 0; i < 15; i++) add_mv(1, 0);
    for (int i = 0; i < 15; i++) add_mv(3, i == 14);
    do_start();
    run_seq(mv, ls, 1);

    // Leaving the grid upward from the start cell.
    mv.delete(); ls.delete();
    add_mv(0, 0);
    do_start();
    run_seq(mv, ls, 0);

    // Wall on the second step.
    mem[17] = 1'b1;
    mv.delete(); ls.delete();
    add_mv(1, 0); add_mv(3, 0);
    do_start();
    run_seq(mv, ls, 0);
    mem[17] = 1'b0;

    // Sequence ends short of the goal.
    mv.delete(); ls.delete();
    add_mv(1, 0); add_mv(3, 1);
    do_start();
    run_seq(mv, ls, 1);

    // Step counter saturation.
    mv.delete(); ls.delete();
    for (int i = 0; i < 262; i++) add_mv((i % 2) ? 2 : 1, 0);
    do_start();
    run_seq(mv, ls, 1);

    // Restart while a move is in CHECK.
    mv.delete(); ls.delete();
    add_mv(1, 0); add_mv(3, 0); add_mv(1, 0);
    do_start();
    run_seq(mv, ls, 0);
    move_valid = 1'b1; move_in = 2'd3; move_last = 1'b0;
    @(negedge clk);
    chk("abort_in_check", move_ready, 0);
    start = 1'b1;
    move_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("abort_pos_valid", pos_valid, 0);
    chk("abort_row", row, 0);
    chk("abort_col", col, 0);
    chk("abort_steps", step_count, 0);
    chk("abort_ready", move_ready, 1);
    chk("abort_addr", addr, 0);

    // Reset while a move is in CHECK.
    mv.delete(); ls.delete();
    add_mv(3, 0); add_mv(3, 0);
    run_seq(mv, ls, 0);
    move_valid = 1'b1; move_in = 2'd1; move_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    move_valid = 1'b0;
    #1;
    chk("rst_mid_row", row, 0);
    chk("rst_mid_col", col, 0);
    chk("rst_mid_steps", step_count, 0);
    chk("rst_mid_pos_valid", pos_valid, 0);
    chk("rst_mid_ready", move_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", move_ready, 0);
    chk("rst_mid_fail", fail_o, 0);

    // Random walks over random wall maps.
    for (int t = 0; t < 40; t++) begin
      int n, x;
      bit fin;
      clear_mem(10);
      mv.delete(); ls.delete();
      n = $urandom_range(1, 40);
      fin = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        x = $urandom % 10;
        add_mv((x < 3) ? 1 : (x < 6) ? 3 : (x < 8) ? 2 : 0,
               fin && (i == n - 1));
      end
      do_start();
      run_seq(mv, ls, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
